ifid_skid_stage: RTL and testbench

Parametrised IF/ID pipeline stage register and successor to the fixed 8-bit hazard-hold stage. It carries PC, incremented PC and the writeback flag from fetch to decode through a two-entry skid buffer. The stage adds a valid/ready handshake, a hazard hold, a flush for branch redirects, and a saturating stall counter for performance monitoring. It sits between the fetch PC logic and the decode stage.

---
 rtl/ifid_skid_stage.sv | 88 ++++++++
 tb/tb_ifid_skid_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID register with a two-entry skid buffer, hazard hold, flush and stall counter.
module ifid_skid_stage #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [PC_W-1:0]  in_pc_inc,
    input  logic             in_wb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [PC_W-1:0]  out_pc_inc,
    output logic             out_wb,
    input  logic             hazard,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int PW = 2 * PC_W + 1;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [PW-1:0]    in_payload;
    logic             accept, pop, stalled;

    assign in_ready   = ~skid_valid_q;
    assign out_valid  = main_valid_q;
    assign {out_pc, out_pc_inc, out_wb} = main_q;
    assign stall_cnt  = stall_q;
    assign in_payload = {in_pc, in_pc_inc, in_wb};
    assign accept     = in_valid & in_ready;
    assign pop        = main_valid_q & out_ready & ~hazard;
    assign stalled    = main_valid_q & (~out_ready | hazard) & ~flush;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        stall_d      = (stalled && stall_q != {CNT_W{1'b1}}) ? stall_q + CNT_W'(1) : stall_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = '0;
            skid_d       = '0;
        end else if (pop) begin
            // the skid entry is always older than the incoming payload
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_payload;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = in_payload;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_payload;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            stall_q      <= stall_d;
        end
    end
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: directed stimulus with a payload scoreboard checked on every pop.
module tb_ifid_skid_stage;
    logic       CLK = 1'b0;
    logic       RST, in_valid, in_ready, in_wb, out_valid, out_ready, out_wb, hazard, flush;
    logic [7:0] in_pc, in_pc_inc, out_pc, out_pc_inc;
    logic [3:0] stall_cnt;
    logic [16:0] exp_q[$];
    logic [16:0] exp_item;
    int tests = 0;
    int fails = 0;

    ifid_skid_stage #(.PC_W(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_pc_inc(in_pc_inc), .in_wb(in_wb), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_inc(out_pc_inc), .out_wb(out_wb), .hazard(hazard),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor and scoreboard share one process so pop-before-push order is fixed.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready && !hazard) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got pc 0x%0h with empty scoreboard", out_pc);
            end else begin
                exp_item = exp_q.pop_front();
                if ({out_pc, out_pc_inc, out_wb} !== exp_item) begin
                    fails++;
                    $display("FAIL pop_payload: got 0x%0h expected 0x%0h", {out_pc, out_pc_inc, out_wb}, exp_item);
                end
            end
        end
        if (RST || flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_pc, in_pc_inc, in_wb});
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] pc, input logic wb);
        in_valid  = v;
        in_pc     = pc;
        in_pc_inc = pc + 8'd1;
        in_wb     = wb;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; out_ready = 1'b0; hazard = 1'b0; flush = 1'b0;
        drive(1'b1, 8'h55, 1'b1);
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        RST = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h10 + 8'(i), i[0]);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", 32'(out_pc), 32'h10 + 32'(i));
            check("stream_pc_inc", 32'(out_pc_inc), 32'h11 + 32'(i));
            check("stream_wb", 32'(out_wb), 32'(i[0]));
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("stream_drain", 32'(out_valid), 32'd0);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        drive(1'b1, 8'h20, 1'b0);
        step();
        hazard = 1'b1;
        drive(1'b1, 8'h21, 1'b1);
        step();
        check("haz_in_ready_low", 32'(in_ready), 32'd0);
        check("haz_stall1", 32'(stall_cnt), 32'd1);
        drive(1'b1, 8'h22, 1'b0);
        step();
        check("haz_main_pc", 32'(out_pc), 32'h20);
        check("haz_in_ready_held", 32'(in_ready), 32'd0);
        check("haz_stall2", 32'(stall_cnt), 32'd2);
        hazard = 1'b0;
        step();
        check("haz_skid_to_main", 32'(out_pc), 32'h21);
        check("haz_in_ready_back", 32'(in_ready), 32'd1);
        step();
        check("haz_third", 32'(out_pc), 32'h22);
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("haz_drain", 32'(out_valid), 32'd0);
        check("haz_stall_final", 32'(stall_cnt), 32'd2);

        pulse_reset();
        check("rst_stall_clear", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 8'h30, 1'b0);
        step();
        drive(1'b1, 8'h31, 1'b1);
        step();
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h32, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_pc", 32'(out_pc), 32'h00);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_no_stall", 32'(stall_cnt), 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 8'h40, 1'b1);
        step();
        drive(1'b1, 8'h41, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check("flush_pop_discard", 32'(out_valid), 32'd0);
        step(); step();
        check("flush_idle", 32'(out_valid), 32'd0);

        pulse_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'h50, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (20) step();
        check("sat_value", 32'(stall_cnt), 32'd15);
        step();
        check("sat_hold", 32'(stall_cnt), 32'd15);
        pulse_reset();
        check("sat_reset", 32'(stall_cnt), 32'd0);

        out_ready = 1'b1;
        hazard = 1'b1;
        drive(1'b1, 8'h60, 1'b1);
        step();
        drive(1'b1, 8'h61, 1'b0);
        step();
        check("rstfull_full", 32'(in_ready), 32'd0);
        RST = 1'b1;
        step();
        check("rstfull_valid", 32'(out_valid), 32'd0);
        check("rstfull_pc", 32'(out_pc), 32'h00);
        check("rstfull_pc_inc", 32'(out_pc_inc), 32'h00);
        check("rstfull_wb", 32'(out_wb), 32'd0);
        check("rstfull_in_ready", 32'(in_ready), 32'd1);
        check("rstfull_stall", 32'(stall_cnt), 32'd0);
        RST = 1'b0;
        hazard = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step(); step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
